// File: rtl/hub75_scan_driver_if.sv
// Pixel-RAM read port and HUB75 panel pins of the scan driver.
interface hub75_scan_driver_if;
   logic [7:0]  o_r_addr;
   logic        o_r_enable;
   logic [15:0] i_r_data_upper;
   logic [15:0] i_r_data_lower;
   logic [5:0]  o_rgb;
   logic        o_sclk;
   logic        o_lat;
   logic        o_oe_n;
   logic [2:0]  o_row;
   logic        o_frame_done;

   modport master (
      output o_r_addr, o_r_enable, o_rgb, o_sclk, o_lat, o_oe_n, o_row, o_frame_done,
      input  i_r_data_upper, i_r_data_lower
   );

   modport slave (
      input  o_r_addr, o_r_enable, o_rgb, o_sclk, o_lat, o_oe_n, o_row, o_frame_done,
      output i_r_data_upper, i_r_data_lower
   );
endinterface

// File: rtl/hub75_scan_driver.sv
// Scans a 32x16 1/8-scan HUB75 panel from two RGB565 RAMs with binary-coded modulation.
// Define HUB75_BRIGHTNESS_EN to add i_brightness, which trims the lit part of each DISPLAY slot.
module hub75_scan_driver #(
   parameter int COLS       = 32,
   parameter int ROWS_HALF  = 8,
   parameter int BITS       = 4,
   parameter int BASE_TICKS = 8
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_enable,
`ifdef HUB75_BRIGHTNESS_EN
   input  logic [7:0] i_brightness,
`endif
   hub75_scan_driver_if.master bus
);
   localparam int COL_W    = $clog2(COLS);
   localparam int ROW_W    = $clog2(ROWS_HALF);
   localparam int DISP_MAX = BASE_TICKS << (BITS - 1);
   localparam int CNT_MAX  = (DISP_MAX > 2 * COLS) ? DISP_MAX : 2 * COLS;
   localparam int CNT_W    = $clog2(CNT_MAX + 1);
   localparam int R_LO     = 16 - BITS;
   localparam int G_LO     = 11 - BITS;
   localparam int B_LO     = 5 - BITS;

   typedef enum logic [2:0] {IDLE, FETCH, SHIFT, LATCH, DISPLAY} state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, disp_len, on_len;
   logic [ROW_W-1:0] row, row_out;
   logic [2:0]       plane;
   logic [5:0]       rgb_q, pix, rgb;
   logic [COL_W-1:0] col;
   logic [3:0]       r_idx, g_idx, b_idx;
   logic [7:0]       r_addr;
   logic             r_en, sclk, lat, oe_n, frame_done_q;
   logic             shift_last, disp_last, plane_last, row_last;

   // SHIFT uses two cycles per column: even cycle presents data, odd cycle raises sclk.
   assign col        = cnt[COL_W:1];
   assign shift_last = (cnt == CNT_W'(2 * COLS - 1));
   assign disp_len   = CNT_W'(BASE_TICKS) << plane;
   assign disp_last  = (cnt == disp_len - 1'b1);
   assign plane_last = (plane == 3'(BITS - 1));
   assign row_last   = (row == ROW_W'(ROWS_HALF - 1));

   assign r_idx = 4'(R_LO + int'(plane));
   assign g_idx = 4'(G_LO + int'(plane));
   assign b_idx = 4'(B_LO + int'(plane));
   assign pix   = {bus.i_r_data_upper[r_idx], bus.i_r_data_upper[g_idx], bus.i_r_data_upper[b_idx],
                   bus.i_r_data_lower[r_idx], bus.i_r_data_lower[g_idx], bus.i_r_data_lower[b_idx]};

`ifdef HUB75_BRIGHTNESS_EN
   logic [7:0]       bright;
   logic [CNT_W+7:0] lit_prod;

   assign lit_prod = (CNT_W + 8)'(disp_len) * (CNT_W + 8)'(bright);
   assign on_len   = lit_prod[CNT_W+7:8];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         bright <= '0;
      else if (state == LATCH)
         bright <= i_brightness;
   end
`else
   assign on_len = disp_len;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      r_addr   = '0;
      r_en     = 1'b0;
      sclk     = 1'b0;
      lat      = 1'b0;
      oe_n     = 1'b1;
      rgb      = rgb_q;
      case (state)
         IDLE: begin
            if (i_enable)
               state_nx = FETCH;
         end
         FETCH: begin
            r_addr   = {row, COL_W'(0)};
            r_en     = 1'b1;
            state_nx = SHIFT;
         end
         SHIFT: begin
            if (!cnt[0]) begin
               rgb = pix;
            end else begin
               sclk = 1'b1;
               if (col != COL_W'(COLS - 1)) begin
                  r_en   = 1'b1;
                  r_addr = {row, col + 1'b1};
               end
            end
            if (shift_last)
               state_nx = LATCH;
         end
         LATCH: begin
            lat      = 1'b1;
            state_nx = DISPLAY;
         end
         DISPLAY: begin
            oe_n = (cnt >= on_len);
            // i_enable only matters once the whole frame has been shown.
            if (disp_last)
               state_nx = (plane_last && row_last && !i_enable) ? IDLE : FETCH;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt          <= '0;
         row          <= '0;
         plane        <= '0;
         row_out      <= '0;
         rgb_q        <= '0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         case (state)
            IDLE: begin
               cnt   <= '0;
               row   <= '0;
               plane <= '0;
            end
            FETCH: cnt <= '0;
            SHIFT: begin
               cnt <= shift_last ? '0 : cnt + 1'b1;
               if (!cnt[0])
                  rgb_q <= pix;
            end
            LATCH: begin
               cnt     <= '0;
               row_out <= row;
            end
            DISPLAY: begin
               if (!disp_last) begin
                  cnt <= cnt + 1'b1;
               end else begin
                  cnt <= '0;
                  if (!plane_last) begin
                     plane <= plane + 1'b1;
                  end else begin
                     plane        <= '0;
                     row          <= row_last ? '0 : row + 1'b1;
                     frame_done_q <= row_last;
                  end
               end
            end
            default: cnt <= '0;
         endcase
      end
   end

   assign bus.o_r_addr     = r_addr;
   assign bus.o_r_enable   = r_en;
   assign bus.o_rgb        = rgb;
   assign bus.o_sclk       = sclk;
   assign bus.o_lat        = lat;
   assign bus.o_oe_n       = oe_n;
   assign bus.o_row        = row_out;
   assign bus.o_frame_done = frame_done_q;
endmodule
